// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver:
// the TX state encoding, the idle line level and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      Idle,
      Start,
      Data,
      Parity,
      Stop
   } uart_tx_state_e;

   localparam logic        IdleLevel    = 1'b1;
   localparam int unsigned MaxDataWidth = 32;

   // Callers zero-extend narrower words; the extra zero bits leave the XOR unchanged.
   function automatic logic calc_parity(input logic [MaxDataWidth-1:0] data,
                                        input logic                    odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and serialises it as
// start, data LSB-first, optional parity and 1-2 stop bits, one bit per baud tick.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int ParityEn  = 0,
   parameter int ParityOdd = 0,
   parameter int StopBits  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 baud_clk_i,
   input  logic                 valid_i,
   input  logic [DataWidth-1:0] data_i,
   output logic                 ready_o,
   output logic                 txd_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int             CntW     = (DataWidth > 1) ? $clog2(DataWidth) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);
   localparam logic           LastStop = 1'(StopBits - 1);
   localparam logic           OddBit   = (ParityOdd != 0);

   uart_tx_state_e       state_q, state_d;
   logic [DataWidth-1:0] shift_q, shift_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= Idle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         txd_q      <= IdleLevel;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      txd_d      = txd_q;
      done_d     = 1'b0;

      case (state_q)
         // The baud tick is deliberately ignored in the accept cycle.
         Idle: begin
            if (valid_i) begin
               shift_d = data_i;
               par_d   = calc_parity(MaxDataWidth'(data_i), OddBit);
               state_d = Start;
            end
         end
         Start: begin
            if (baud_clk_i) begin
               txd_d      = 1'b0;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               state_d    = Data;
            end
         end
         Data: begin
            if (baud_clk_i) begin
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LastBit) begin
                  state_d = (ParityEn != 0) ? Parity : Stop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         Parity: begin
            if (baud_clk_i) begin
               txd_d   = par_q;
               state_d = Stop;
            end
         end
         Stop: begin
            if (baud_clk_i) begin
               txd_d = IdleLevel;
               if (stop_cnt_q == LastStop) begin
                  state_d = Idle;
                  done_d  = 1'b1;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = Idle;
      endcase
   end

   assign ready_o = (state_q == Idle);
   assign busy_o  = (state_q != Idle);
   assign txd_o   = txd_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O1) sharing one clock and baud tick,
// checked with a directed vector table, hand sequences and random frames against a frame model.
module tb_uart_tx;

   localparam int BAUD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud = 1'b0;
   logic [2:0] valid = '0;
   logic [7:0] data [3];
   logic [2:0] ready, txd, busy, done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         baud = ((cyc % BAUD) == 0);
      end
   end

   uart_tx #(.DataWidth(8), .ParityEn(0), .ParityOdd(0), .StopBits(1)) u0 (
      .clk_i(clk), .rst_i(rst), .baud_clk_i(baud), .valid_i(valid[0]), .data_i(data[0]),
      .ready_o(ready[0]), .txd_o(txd[0]), .busy_o(busy[0]), .done_o(done[0]));
   uart_tx #(.DataWidth(8), .ParityEn(1), .ParityOdd(0), .StopBits(2)) u1 (
      .clk_i(clk), .rst_i(rst), .baud_clk_i(baud), .valid_i(valid[1]), .data_i(data[1]),
      .ready_o(ready[1]), .txd_o(txd[1]), .busy_o(busy[1]), .done_o(done[1]));
   uart_tx #(.DataWidth(8), .ParityEn(1), .ParityOdd(1), .StopBits(1)) u2 (
      .clk_i(clk), .rst_i(rst), .baud_clk_i(baud), .valid_i(valid[2]), .data_i(data[2]),
      .ready_o(ready[2]), .txd_o(txd[2]), .busy_o(busy[2]), .done_o(done[2]));

   function automatic int pen_of(int k);  return (k == 0) ? 0 : 1; endfunction
   function automatic int odd_of(int k);  return (k == 2) ? 1 : 0; endfunction
   function automatic int stop_of(int k); return (k == 1) ? 2 : 1; endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Line may only move on a baud tick or reset.
   logic [2:0] mon_prev;
   logic       mon_b, mon_r;
   always @(posedge clk) begin
      mon_prev = txd;
      mon_b    = baud;
      mon_r    = rst;
      #1;
      if (!mon_b && !mon_r) chk("txd_stable_between_ticks", 32'(txd), 32'(mon_prev));
   end

   // Frame model: list of line levels, one per bit period, in transmit order.
   function automatic void model(input int k, input logic [7:0] w,
                                 output logic [15:0] f, output int n);
      f = '0;
      n = 0;
      f[n] = 1'b0; n++;
      for (int i = 0; i < 8; i++) begin f[n] = w[i]; n++; end
      if (pen_of(k) != 0) begin
         f[n] = (($countones(w) + odd_of(k)) % 2) == 1;
         n++;
      end
      for (int s = 0; s < stop_of(k); s++) begin f[n] = 1'b1; n++; end
   endfunction

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * BAUD; i++) begin
         @(posedge clk);
         if (baud) begin ok = 1'b1; break; end
      end
      #1;
   endtask

   task automatic wait_ready(input int k);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ready[k]) begin got = 1'b1; break; end
      end
      if (!got) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send(input int k, input logic [7:0] w);
      wait_ready(k);
      valid[k] = 1'b1;
      data[k]  = w;
      @(posedge clk);
      #1;
      valid[k] = 1'b0;
      data[k]  = 8'($urandom);
   endtask

   task automatic frame_check(input int k, input logic [15:0] exp, input int n, input string nm,
                              output int first_cyc, output int last_cyc);
      bit ok;
      first_cyc = 0;
      last_cyc  = 0;
      for (int i = 0; i < n; i++) begin
         wait_tick(ok);
         if (!ok) begin
            chk({nm, "_tick_timeout"}, 32'd0, 32'd1);
            return;
         end
         if (i == 0) first_cyc = cyc;
         last_cyc = cyc;
         chk($sformatf("%s_bit%0d", nm, i), 32'(txd[k]), 32'(exp[i]));
         if (i == n - 1)
            chk({nm, "_end_rdy_busy_done"}, {29'd0, ready[k], busy[k], done[k]}, 32'b101);
         else
            chk($sformatf("%s_mid%0d_rdy_busy_done", nm, i),
                {29'd0, ready[k], busy[k], done[k]}, 32'b010);
      end
      @(posedge clk);
      #1;
      chk({nm, "_done_one_cycle"}, 32'(done[k]), 32'd0);
   endtask

   typedef struct {
      int          k;
      logic [7:0]  w;
      logic [15:0] exp;
      int          n;
      string       nm;
   } vec_t;

   vec_t tbl[8];

   initial begin : main
      logic [15:0] f;
      int          n, f1, l1, f2, l2;
      bit          ok;

      for (int k = 0; k < 3; k++) data[k] = '0;

      tbl[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}),        10, "8N1_A5"};
      tbl[1] = '{1, 8'hA5, 16'({2'b11, 1'b0, 8'hA5, 1'b0}), 12, "8E2_A5"};
      tbl[2] = '{2, 8'hA5, 16'({1'b1, 1'b1, 8'hA5, 1'b0}),  11, "8O1_A5"};
      tbl[3] = '{1, 8'h01, 16'({2'b11, 1'b1, 8'h01, 1'b0}), 12, "8E2_01"};
      tbl[4] = '{2, 8'h01, 16'({1'b1, 1'b0, 8'h01, 1'b0}),  11, "8O1_01"};
      tbl[5] = '{1, 8'hFF, 16'({2'b11, 1'b0, 8'hFF, 1'b0}), 12, "8E2_FF"};
      tbl[6] = '{0, 8'h00, 16'({1'b1, 8'h00, 1'b0}),        10, "8N1_00"};
      tbl[7] = '{2, 8'h80, 16'({1'b1, 1'b0, 8'h80, 1'b0}),  11, "8O1_80"};

      // Reset and idle line
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {20'd0, txd, ready, busy, done}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
      rst = 1'b0;
      for (int i = 0; i < 20 * BAUD; i++) begin
         @(posedge clk);
         #1;
         chk("idle_state", {20'd0, txd, ready, busy, done}, {20'd0, 3'b111, 3'b111, 3'b000, 3'b000});
      end

      // Directed table
      for (int t = 0; t < 8; t++) begin
         send(tbl[t].k, tbl[t].w);
         frame_check(tbl[t].k, tbl[t].exp, tbl[t].n, tbl[t].nm, f1, l1);
      end

      // Streaming: valid held high across two words
      wait_ready(0);
      valid[0] = 1'b1;
      data[0]  = 8'h3C;
      @(posedge clk);
      #1;
      data[0] = 8'hC3;
      frame_check(0, 16'({1'b1, 8'h3C, 1'b0}), 10, "stream_3C", f1, l1);
      valid[0] = 1'b0;
      data[0]  = 8'h00;
      frame_check(0, 16'({1'b1, 8'hC3, 1'b0}), 10, "stream_C3", f2, l2);
      chk("stream_stop_to_start_cycles", 32'(f2 - l1), 32'(BAUD));

      // Reset in the middle of data bit 3
      send(0, 8'h55);
      model(0, 8'h55, f, n);
      for (int i = 0; i < 5; i++) begin
         wait_tick(ok);
         chk($sformatf("abort_bit%0d", i), 32'(txd[0]), 32'(f[i]));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_reset_state", {28'd0, txd[0], ready[0], busy[0], done[0]}, 32'b1100);
      rst = 1'b0;
      for (int i = 0; i < 3 * BAUD; i++) begin
         @(posedge clk);
         #1;
         chk("abort_quiet", {29'd0, txd[0], busy[0], done[0]}, 32'b100);
      end
      send(0, 8'h55);
      frame_check(0, f, n, "after_abort_55", f1, l1);

      // Random frames against the model
      for (int r = 0; r < 24; r++) begin
         int         k;
         logic [7:0] w;
         k = int'($urandom_range(0, 2));
         w = 8'($urandom);
         model(k, w, f, n);
         send(k, w);
         frame_check(k, f, n, $sformatf("rand%0d_u%0d_%02h", r, k, w), f1, l1);
         repeat ($urandom_range(0, 6)) @(posedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
